fetch_ip_stage: RTL
===================

Name: fetch_ip_stage

Overview:
- Fetch-address stage directly downstream of the PC unit.
- Owns the architectural fetch IP register and feeds it back as oldIPBase.
- Issues one aligned fetch request at a time to instruction memory.
- Hands the fetched word to decode with a valid/ready handshake; on a redirect it latches the PC unit's newIP/newSize and kills any in-flight fetch.

Parameters:
- MWORD_SIZE, 32: machine word / address width.
- SMALL_NUMBER_SIZE, 8: width of the size field.
- ALIGN_BITS, 2: log2 of fetch-block bytes.
- RESET_IP, 0: IP loaded at reset.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- en  in  1  fetch enable; leaves IDLE.
- newIP  in  MWORD_SIZE  next IP from PC unit.
- newSize  in  SMALL_NUMBER_SIZE  size paired with newIP.
- redirect  in  1  OR of PC-unit selectInt/Exc/Target/Result; newIP is a non-sequential target.
- ipBase  out  MWORD_SIZE  current fetch IP, wired to PC unit oldIPBase.
- memReq  out  1  fetch request valid.
- memAddr  out  MWORD_SIZE  ipBase with low ALIGN_BITS forced to 0.
- memAck  in  1  request accepted this cycle (only meaningful while memReq=1).
- memRspValid  in  1  response data valid.
- memRspData  in  MWORD_SIZE  fetched word.
- outValid  out  1  fetched block valid to decode.
- outIP  out  MWORD_SIZE  IP of held block.
- outSize  out  SMALL_NUMBER_SIZE  size of held block.
- outData  out  MWORD_SIZE  held word.
- outReady  in  1  decode accepts.

Behaviour:
- Reset: state=IDLE, ipBase=RESET_IP, ipSize=(1<<ALIGN_BITS)>>1 (=2), drop=0, memReq=0, outValid=0, outIP/outSize/outData=0. Reset mid-operation discards everything; late memRspValid after reset is ignored (drop cleared, state IDLE).
- States:
  - IDLE: en=1 -> REQ.
  - REQ: memReq=1, memAddr stable while no redirect. memAck -> WAIT.
  - WAIT: memRspValid -> latch outData/outIP=ipBase/outSize=ipSize, go HOLD. If drop=1, discard the response, clear drop, go REQ.
  - HOLD: outValid=1. outValid&outReady -> ipBase<=newIP, ipSize<=newSize (sequential increment from PC unit), go REQ.
- Registered outputs: memReq/outValid decode from state. outIP/outSize/outData stay constant while outValid=1 and no handshake.
- Redirect, any non-IDLE state (priority over everything except reset): ipBase<=newIP, ipSize<=newSize.
  - In REQ without memAck: stay REQ; new address presented next cycle.
  - In REQ with memAck the same cycle: go WAIT with drop=1.
  - In WAIT: drop<=1, stay WAIT; memRspValid in the same cycle as redirect is discarded and state goes REQ with drop=0.
  - In HOLD: outValid drops next cycle and the held block is killed even if outReady=1 that cycle; go REQ.
  - In IDLE: register update only.
- Outstanding requests: at most 1. memAck outside REQ and memRspValid outside WAIT are ignored.
- Arithmetic: none inside this block; all increment and wrap-around come from the PC unit (0xFFFFFFFC -> 0x00000000 accepted as is).
- Throughput: 3 cycles per block with 1-cycle memory latency and outReady=1.

Decomposition:
- Shared package holds MWORD_SIZE, SMALL_NUMBER_SIZE, ALIGN_BITS, RESET_IP and the state encoding (IDLE, REQ, WAIT, HOLD).
- One natural sub-module: fetch_out_buffer, the HOLD register with valid/ready and kill.

Test Plan:
- Reset then en=1, newIP=4, newSize=2, memAck at cycle 1, rsp 0xDEADBEEF at cycle 2 -> memAddr=0, then outValid with outIP=0, outSize=2, outData=0xDEADBEEF; after outReady, ipBase=4.
- Redirect in WAIT to newIP=0x102, newSize=1 -> pending response discarded, no outValid; next memAddr=0x100; resulting block outIP=0x102, outSize=1.
- Redirect with outReady=1 in HOLD -> block not consumed; outValid=0 next cycle; ipBase=redirect target.
- outReady held 0 for 5 cycles -> outValid, outIP, outData stable; memReq stays 0.
- memAck and redirect in the same cycle -> state WAIT, drop=1; next response dropped; REQ reissued at the new address.
- Reset asserted in WAIT, response arrives next cycle -> ignored; outValid=0; ipBase=RESET_IP.

Source files
------------

// File: rtl/fetch_ip_stage_pkg.sv
// Shared widths, reset values and the fetch FSM state encoding.
package fetch_ip_stage_pkg;

  localparam int MWORD_SIZE        = 32;
  localparam int SMALL_NUMBER_SIZE = 8;
  localparam int ALIGN_BITS        = 2;

  localparam logic [MWORD_SIZE-1:0]        RESET_IP   = '0;
  localparam logic [SMALL_NUMBER_SIZE-1:0] RESET_SIZE = SMALL_NUMBER_SIZE'((1 << ALIGN_BITS) >> 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_out_buffer.sv
// Holds one fetched block for decode; valid/ready handshake, kill wins over everything but reset.
module fetch_out_buffer
  import fetch_ip_stage_pkg::*;
(
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         load_i,
  input  logic                         kill_i,
  input  logic                         ready_i,
  input  logic [MWORD_SIZE-1:0]        ip_i,
  input  logic [SMALL_NUMBER_SIZE-1:0] size_i,
  input  logic [MWORD_SIZE-1:0]        data_i,
  output logic                         valid_o,
  output logic [MWORD_SIZE-1:0]        ip_o,
  output logic [SMALL_NUMBER_SIZE-1:0] size_o,
  output logic [MWORD_SIZE-1:0]        data_o
);

  logic                         valid_q, valid_d;
  logic [MWORD_SIZE-1:0]        ip_q, ip_d;
  logic [SMALL_NUMBER_SIZE-1:0] size_q, size_d;
  logic [MWORD_SIZE-1:0]        data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    ip_d    = ip_q;
    size_d  = size_q;
    data_d  = data_q;
    if (kill_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      ip_d    = ip_i;
      size_d  = size_i;
      data_d  = data_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q <= 1'b0;
      ip_q    <= '0;
      size_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ip_q    <= ip_d;
      size_q  <= size_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign ip_o    = ip_q;
  assign size_o  = size_q;
  assign data_o  = data_q;

endmodule

// File: rtl/fetch_ip_stage.sv
// Fetch-address stage: owns the fetch IP, issues one aligned request at a time and
// hands the fetched word to decode; a redirect retargets the IP and kills in-flight work.
module fetch_ip_stage
  import fetch_ip_stage_pkg::*;
(
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         en_i,
  input  logic [MWORD_SIZE-1:0]        newIP_i,
  input  logic [SMALL_NUMBER_SIZE-1:0] newSize_i,
  input  logic                         redirect_i,
  output logic [MWORD_SIZE-1:0]        ipBase_o,
  output logic                         memReq_o,
  output logic [MWORD_SIZE-1:0]        memAddr_o,
  input  logic                         memAck_i,
  input  logic                         memRspValid_i,
  input  logic [MWORD_SIZE-1:0]        memRspData_i,
  output logic                         outValid_o,
  output logic [MWORD_SIZE-1:0]        outIP_o,
  output logic [SMALL_NUMBER_SIZE-1:0] outSize_o,
  output logic [MWORD_SIZE-1:0]        outData_o,
  input  logic                         outReady_i
);

  fetch_state_e                 state_q, state_d;
  logic [MWORD_SIZE-1:0]        ip_base_q, ip_base_d;
  logic [SMALL_NUMBER_SIZE-1:0] ip_size_q, ip_size_d;
  logic                         drop_q, drop_d;
  logic                         buf_load, buf_kill, consume;

  assign consume = outValid_o && outReady_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      ip_base_q <= RESET_IP;
      ip_size_q <= RESET_SIZE;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ip_base_q <= ip_base_d;
      ip_size_q <= ip_size_d;
      drop_q    <= drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (en_i) state_d = ST_REQ;
      ST_REQ:  if (memAck_i) state_d = ST_WAIT;
      ST_WAIT: begin
        if (memRspValid_i) state_d = (redirect_i || drop_q) ? ST_REQ : ST_HOLD;
      end
      ST_HOLD: if (redirect_i || consume) state_d = ST_REQ;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    memReq_o = (state_q == ST_REQ);
    buf_load = (state_q == ST_WAIT) && memRspValid_i && !redirect_i && !drop_q;
    buf_kill = (state_q == ST_HOLD) && redirect_i;
  end

  // Redirect overrides the sequential IP handed over on a consume.
  always_comb begin
    ip_base_d = ip_base_q;
    ip_size_d = ip_size_q;
    drop_d    = drop_q;
    if (redirect_i || (state_q == ST_HOLD && consume)) begin
      ip_base_d = newIP_i;
      ip_size_d = newSize_i;
    end
    if (state_q == ST_REQ && memAck_i) begin
      drop_d = redirect_i;
    end else if (state_q == ST_WAIT) begin
      if (memRspValid_i)   drop_d = 1'b0;
      else if (redirect_i) drop_d = 1'b1;
    end
  end

  assign ipBase_o  = ip_base_q;
  assign memAddr_o = {ip_base_q[MWORD_SIZE-1:ALIGN_BITS], {ALIGN_BITS{1'b0}}};

  fetch_out_buffer u_out_buffer (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .load_i  (buf_load),
    .kill_i  (buf_kill),
    .ready_i (outReady_i),
    .ip_i    (ip_base_q),
    .size_i  (ip_size_q),
    .data_i  (memRspData_i),
    .valid_o (outValid_o),
    .ip_o    (outIP_o),
    .size_o  (outSize_o),
    .data_o  (outData_o)
  );

endmodule
